// File: rtl/lcd_frame_sequencer.sv
// lcd_frame_sequencer: drives the LCD configuration sequence after reset, then
// streams a 2x16 character frame buffer as 11-bit command words.
// Optional feature: define LCD_SEQ_AUTO_REFRESH_EN to refresh the display
// automatically after REFRESH_CYCLES idle cycles.
module lcd_frame_sequencer #(
    parameter int CLEAR_WAIT     = 82000,
    parameter int REFRESH_CYCLES = 2500000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        next_command,
    input  logic        char_we,
    input  logic [4:0]  char_addr,
    input  logic [7:0]  char_data,
    input  logic        refresh_req,
    output logic [10:0] cmd_word,
    output logic        busy,
    output logic        frame_done
);

    typedef enum logic [3:0] {
        INIT_FS, INIT_EM, INIT_DON, INIT_CLR, CLR_WAIT,
        IDLE, ADDR1, LINE1, ADDR2, LINE2
    } state_t;

    localparam int CW = (CLEAR_WAIT > 1) ? $clog2(CLEAR_WAIT) : 1;

    state_t          state_reg, state_next;
    logic [4:0]      index_reg, index_next;
    logic [CW-1:0]   clr_cnt_reg, clr_cnt_next;
    logic            pending_reg, pending_next;
    logic            auto_fire;
    logic [7:0]      buffer [32];
    logic [31:0]     buf_we;
    logic [7:0]      rd_data;
    logic [10:0]     cmd_next;
    logic            busy_next;
    logic            frame_done_next;

    // Per-entry write enables for the frame buffer.
    for (genvar gi = 0; gi < 32; gi++) begin : g_we
        assign buf_we[gi] = char_we && (char_addr == 5'(gi));
    end

    // Frame buffer: 32 characters, cleared to spaces on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) buffer[i] <= 8'h20;
        end else begin
            for (int i = 0; i < 32; i++) begin
                if (buf_we[i]) buffer[i] <= char_data;
            end
        end
    end

`ifdef LCD_SEQ_AUTO_REFRESH_EN
    logic [21:0] refresh_cnt_reg;

    assign auto_fire = (state_reg == IDLE) && !refresh_req &&
                       (refresh_cnt_reg == 22'(REFRESH_CYCLES - 1));

    // Idle-time counter: requests a refresh after REFRESH_CYCLES idle cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            refresh_cnt_reg <= '0;
        else if (state_reg != IDLE || refresh_req || auto_fire)
            refresh_cnt_reg <= '0;
        else
            refresh_cnt_reg <= refresh_cnt_reg + 22'd1;
    end
`else
    // Auto-refresh compiled out; a non-positive period is never meaningful.
    assign auto_fire = (REFRESH_CYCLES < 0);
`endif

    // Pending refresh: any request sets it, starting a frame clears it.
    always_comb begin
        pending_next = pending_reg;
        if (state_reg == IDLE && pending_reg) pending_next = 1'b0;
        if (auto_fire || refresh_req)         pending_next = 1'b1;
    end

    // State, index, clear-wait counter and pending flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= INIT_FS;
            index_reg   <= '0;
            clr_cnt_reg <= '0;
            pending_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            index_reg   <= index_next;
            clr_cnt_reg <= clr_cnt_next;
            pending_reg <= pending_next;
        end
    end

    // Next-state logic: init commands and frame words advance on next_command.
    always_comb begin
        state_next   = state_reg;
        index_next   = index_reg;
        clr_cnt_next = clr_cnt_reg;
        case (state_reg)
            INIT_FS:  if (next_command) state_next = INIT_EM;
            INIT_EM:  if (next_command) state_next = INIT_DON;
            INIT_DON: if (next_command) state_next = INIT_CLR;
            INIT_CLR: if (next_command) begin
                state_next   = CLR_WAIT;
                clr_cnt_next = '0;
            end
            CLR_WAIT: begin
                if (clr_cnt_reg == CW'(CLEAR_WAIT - 1))
                    state_next = IDLE;
                else
                    clr_cnt_next = clr_cnt_reg + 1'b1;
            end
            IDLE:     if (pending_reg) state_next = ADDR1;
            ADDR1:    if (next_command) begin
                state_next = LINE1;
                index_next = 5'd0;
            end
            LINE1:    if (next_command) begin
                if (index_reg == 5'd15) state_next = ADDR2;
                index_next = index_reg + 5'd1;
            end
            ADDR2:    if (next_command) begin
                state_next = LINE2;
                index_next = 5'd16;
            end
            LINE2:    if (next_command) begin
                if (index_reg == 5'd31) state_next = IDLE;
                else                    index_next = index_reg + 5'd1;
            end
            default:  state_next = INIT_FS;
        endcase
    end

    // Output decode for the upcoming state; a same-cycle write is forwarded.
    always_comb begin
        rd_data = (char_we && char_addr == index_next) ? char_data : buffer[index_next];
        case (state_next)
            INIT_FS:  cmd_next = 11'h428;
            INIT_EM:  cmd_next = 11'h406;
            INIT_DON: cmd_next = 11'h40C;
            INIT_CLR: cmd_next = 11'h401;
            CLR_WAIT: cmd_next = 11'h001;
            IDLE:     cmd_next = 11'h40C;
            ADDR1:    cmd_next = 11'h480;
            ADDR2:    cmd_next = 11'h4C0;
            LINE1,
            LINE2:    cmd_next = {3'b110, rd_data};
            default:  cmd_next = 11'h428;
        endcase
        busy_next       = (state_next != IDLE);
        frame_done_next = (state_reg == LINE2) && next_command && (index_reg == 5'd31);
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmd_word   <= 11'h428;
            busy       <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            cmd_word   <= cmd_next;
            busy       <= busy_next;
            frame_done <= frame_done_next;
        end
    end

endmodule

// File: doc/lcd_frame_sequencer.md
# lcd_frame_sequencer

Command and text sequencer for the LCD 4-bit nibble interface. Issues the display configuration sequence after reset, then streams a 32-character, 2×16 frame buffer to the display on request, one 11-bit command word at a time. Sits between the user/character logic and `sync_10bit_interface`. Drives that block's `UNMODULATED_DATA` input and advances on its `next_command` pulse.

## Interface
- `CLEAR_WAIT`, default 82000: cycles to hold off after Clear Display (1.64 ms at 50 MHz).
- `REFRESH_CYCLES`, default 2500000: auto-refresh period (used only with `LCD_SEQ_AUTO_REFRESH_EN`).
- `clk`  in  1  system clock, 50 MHz.
- `reset`  in  1  asynchronous, active-low reset.
- `next_command`  in  1  one-cycle pulse from the interface: current `cmd_word` consumed.
- `char_we`  in  1  frame buffer write strobe.
- `char_addr`  in  5  buffer index. 0–15 is line 1, 16–31 is line 2.
- `char_data`  in  8  ASCII byte.
- `refresh_req`  in  1  one-cycle pulse: send the whole buffer to the display.
- `cmd_word`  out  11  [10] valid (0 = request long hold), [9] RS, [8] always 0, [7:0] command/data byte.
- `busy`  out  1  high during init or frame transfer.
- `frame_done`  out  1  one-cycle pulse when a frame transfer completes.

## Operation
- States: INIT_FS, INIT_EM, INIT_DON, INIT_CLR, CLR_WAIT, IDLE, ADDR1, LINE1, ADDR2, LINE2.
- Words per state (RS=0 unless noted):
  - INIT_FS: 0x28. INIT_EM: 0x06. INIT_DON: 0x0C. INIT_CLR: 0x01.
  - CLR_WAIT: bit10=0, RS=0, byte 0x01.
  - IDLE: 0x0C, a harmless display-on filler.
  - ADDR1: 0x80. ADDR2: 0xC0.
  - LINE1/LINE2: RS=1, byte = buffer[index].
- Transitions:
  - INIT states advance in order on `next_command`. INIT_CLR→CLR_WAIT on `next_command`.
  - CLR_WAIT: ignores `next_command`. Counts `CLEAR_WAIT` cycles, then goes to IDLE.
  - IDLE→ADDR1 when a refresh is pending. On entry the pending flag clears and `busy` rises.
  - ADDR1→LINE1, index 0.
  - LINE1: each `next_command` increments index. After index 15 is consumed, go to ADDR2.
  - ADDR2→LINE2, index 16.
  - LINE2: after index 31 is consumed, go to IDLE and pulse `frame_done`.
  - IDLE consumes `next_command` pulses without effect.
- Refresh pending flag:
  - Set by `refresh_req` in any state. Multiple requests during one frame collapse into one pending refresh.
  - `refresh_req` on the same cycle as frame completion gives one new frame, starting from IDLE on the next cycle.
- Frame buffer: 32×8 registers.
  - A `char_we` write lands at the clock edge.
  - A write to the index currently being sent changes `cmd_word` on the next cycle. Data is sampled by the interface when it latches.
  - `char_addr` is 5 bits, so there is no out-of-range case.
- Index counter: 5 bits; wraps to 0 only via ADDR1.

## Timing
- Reset (`reset`=0, asynchronous):
  - State INIT_FS; `cmd_word` = 11'h428; `busy` = 1; `frame_done` = 0.
  - Buffer = 0x20 (space) in all 32 entries; pending = 0; counters = 0.
- `cmd_word` is registered. It updates on the first edge after `next_command` is sampled high, giving 1-cycle latency, and is otherwise stable.
- `busy`:
  - Falls on the cycle CLR_WAIT→IDLE.
  - Rises on the edge leaving IDLE for ADDR1.
  - Falls with `frame_done`.
- Frame = 34 commands: 2 address writes plus 32 data writes.
- CLR_WAIT lasts exactly `CLEAR_WAIT` cycles after entry. `cmd_word[10]`=0 throughout.
- Reset assertion mid-frame aborts immediately. Init restarts on release; pending is lost.

## Configuration
- `LCD_SEQ_AUTO_REFRESH_EN` defined:
  - A 22-bit counter runs in IDLE and sets pending after `REFRESH_CYCLES` idle cycles.
  - The counter clears on leaving IDLE and on any `refresh_req`.
- Not defined: no counter; frames are sent only on `refresh_req`. `REFRESH_CYCLES` is ignored.

## Test plan
- Release reset, pulse `next_command` every 64 cycles. Expect:
  - `cmd_word` sequence 0x428, 0x406, 0x40C, 0x401.
  - Then 0x001 for 82000 cycles, then 0x40C.
  - `busy` falls.
- Write "HELLO" at 0–4 and "WORLD" at 16–20, pulse `refresh_req`. Expect:
  - 0x480, 0x648 'H', …, 0x64F 'O', 0x620 for 11 entries.
  - 0x4C0, 0x657 'W', …, then 11 spaces.
  - `frame_done` after the 34th consumption.
- Three `refresh_req` pulses during a frame: exactly one extra frame follows.
- `refresh_req` coincident with the `frame_done` cycle: next frame starts at 0x480 with no IDLE filler consumed.
- Write index 5 with 0x41 while index 5 is presented: `cmd_word` = 0x641 the next cycle.
- Assert reset mid-LINE2: outputs return to reset values asynchronously; with `LCD_SEQ_AUTO_REFRESH_EN`, an idle frame starts after `REFRESH_CYCLES`.
